pb_debounce_array: RTL and testbench

//  N-channel push-button conditioner for the game's player-input pads.

---
 rtl/pb_debounce_array_pkg.sv | 19 +
 rtl/pb_debounce_chan.sv | 113 +++++++++++
 rtl/pb_debounce_array.sv | 42 ++++
 tb/tb_pb_debounce_array.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_debounce_array_pkg.sv
// Board-level timing constants shared by the push-button conditioner.
package pb_debounce_array_pkg;

    // Board system clock frequency in Hz.
    localparam int unsigned BOARD_CLK_HZ      = 100_000_000;

    // Default channel count for the player-input pads.
    localparam int unsigned DEF_N_CH          = 4;

    // 10 ms of stable level before the debounced output follows.
    localparam int unsigned DEF_STABLE_CYCLES = BOARD_CLK_HZ / 100;

    // 500 ms hold before the first auto-repeat pulse.
    localparam int unsigned DEF_REPEAT_DELAY  = BOARD_CLK_HZ / 2;

    // 100 ms between subsequent auto-repeat pulses.
    localparam int unsigned DEF_REPEAT_PERIOD = BOARD_CLK_HZ / 10;

endpackage

// File: rtl/pb_debounce_chan.sv
// One push-button channel: 2-flop synchroniser, stable-count debouncer,
// press/release pulses and optional auto-repeat.
module pb_debounce_chan
    import pb_debounce_array_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic pbreg,
    output logic press,
    output logic release_pulse,
    output logic rpt
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RCNT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] R_FIRST  = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] R_NEXT   = RCNT_W'(REPEAT_DELAY + REPEAT_PERIOD);

    logic              s1;
    logic              s2;
    logic [CNT_W-1:0]  cnt;
    logic [RCNT_W-1:0] rcnt;

    logic              differ_c;
    logic              done_c;
    logic              rise_c;
    logic              fall_c;
    logic              held_c;
    logic [RCNT_W-1:0] rcnt_inc_c;
    logic              rpt_hit_c;

    // Debounce and repeat decisions taken at the coming edge.
    always_comb begin
        differ_c   = 1'b0;
        done_c     = 1'b0;
        rise_c     = 1'b0;
        fall_c     = 1'b0;
        held_c     = 1'b0;
        rcnt_inc_c = '0;
        rpt_hit_c  = 1'b0;

        differ_c   = (s2 != pbreg);
        done_c     = differ_c && (cnt == CNT_LAST);
        rise_c     = done_c && s2;
        fall_c     = done_c && !s2;
        // A release edge ends the hold, so no repeat can fire alongside it.
        held_c     = pbreg && !fall_c;
        rcnt_inc_c = rcnt + RCNT_W'(1);
        rpt_hit_c  = held_c && ((rcnt_inc_c == R_FIRST) || (rcnt_inc_c == R_NEXT));
    end

    // Synchroniser holds the pressed sense; reset value is the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= button ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    // Stable-count debouncer with registered press/release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            pbreg         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= rise_c;
            release_pulse <= fall_c;
            if (!differ_c) begin
                cnt <= '0;
            end else if (done_c) begin
                pbreg <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Repeat counter: restarts on each debounced edge; after the first pulse
    // it folds back to the delay point, so it is bounded and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            rpt  <= 1'b0;
        end else begin
            rpt <= REPEAT_EN && rpt_hit_c;
            if (rise_c || fall_c) begin
                rcnt <= '0;
            end else if (held_c && REPEAT_EN) begin
                if (rcnt_inc_c == R_NEXT) begin
                    rcnt <= R_FIRST;
                end else begin
                    rcnt <= rcnt_inc_c;
                end
            end
        end
    end

endmodule

// File: rtl/pb_debounce_array.sv
// N-channel push-button conditioner for the player-input pads.
// The release pulse port is named release_pulse because release is a
// reserved word in SystemVerilog.
module pb_debounce_array
    import pb_debounce_array_pkg::*;
#(
    parameter int unsigned N_CH          = DEF_N_CH,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] pbreg,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] rpt
);

    // Channels are fully independent; one conditioner per pad.
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_chan
        pb_debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .button        (button[i]),
            .pbreg         (pbreg[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .rpt           (rpt[i])
        );
    end

endmodule

// File: tb/tb_pb_debounce_array.sv
// Directed bench for pb_debounce_array with short debounce/repeat timings.
module tb_pb_debounce_array;

    logic       clk;
    logic       rst_n;
    logic [3:0] button;
    logic [3:0] pbreg;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] rpt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pb_debounce_array #(
        .N_CH          (4),
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b0),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button        (button),
        .pbreg         (pbreg),
        .press         (press),
        .release_pulse (release_pulse),
        .rpt           (rpt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one active edge and settle before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] exp_pb;
        logic [3:0] exp_ev;
        button = 4'hF;
        rst_n  = 1'b1;
        #2;
        rst_n  = 1'b0;
        #1;
        chk_cnt++;
        if ({pbreg, press, release_pulse, rpt} !== 16'h0)
            $display("FAIL reset_async: got %h required 0000", {pbreg, press, release_pulse, rpt});
        else pass_cnt++;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_cnt++;
            if ({pbreg, press, release_pulse, rpt} !== 16'h0)
                $display("FAIL reset_hold edge %0d: got %h required 0000", k, {pbreg, press, release_pulse, rpt});
            else pass_cnt++;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_pb = (k >= 6) ? 4'hF : 4'h0;
            exp_ev = (k == 6) ? 4'hF : 4'h0;
            chk_cnt++;
            if (pbreg !== exp_pb)
                $display("FAIL reset_pbreg edge %0d: got %h required %h", k, pbreg, exp_pb);
            else pass_cnt++;
            chk_cnt++;
            if (press !== exp_ev)
                $display("FAIL reset_press edge %0d: got %h required %h", k, press, exp_ev);
            else pass_cnt++;
        end
        button = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_pb = (k < 6) ? 4'hF : 4'h0;
            exp_ev = (k == 6) ? 4'hF : 4'h0;
            chk_cnt++;
            if (pbreg !== exp_pb)
                $display("FAIL reset_rel_pbreg edge %0d: got %h required %h", k, pbreg, exp_pb);
            else pass_cnt++;
            chk_cnt++;
            if (release_pulse !== exp_ev)
                $display("FAIL reset_release edge %0d: got %h required %h", k, release_pulse, exp_ev);
            else pass_cnt++;
        end
    endtask

    task automatic test_clean_press;
        logic [3:0] exp_pb;
        logic [3:0] exp_ev;
        button = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_pb = (k >= 6) ? 4'h1 : 4'h0;
            exp_ev = (k == 6) ? 4'h1 : 4'h0;
            chk_cnt++;
            if (pbreg !== exp_pb)
                $display("FAIL clean_pbreg edge %0d: got %h required %h", k, pbreg, exp_pb);
            else pass_cnt++;
            chk_cnt++;
            if ({press, release_pulse, rpt} !== {exp_ev, 8'h00})
                $display("FAIL clean_press edge %0d: got %h required %h", k, {press, release_pulse, rpt}, {exp_ev, 8'h00});
            else pass_cnt++;
        end
        button = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_pb = (k < 6) ? 4'h1 : 4'h0;
            exp_ev = (k == 6) ? 4'h1 : 4'h0;
            chk_cnt++;
            if (pbreg !== exp_pb)
                $display("FAIL clean_rel_pbreg edge %0d: got %h required %h", k, pbreg, exp_pb);
            else pass_cnt++;
            chk_cnt++;
            if ({press, release_pulse, rpt} !== {4'h0, exp_ev, 4'h0})
                $display("FAIL clean_release edge %0d: got %h required %h", k, {press, release_pulse, rpt}, {4'h0, exp_ev, 4'h0});
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch;
        button = 4'h2;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) button = 4'h0;
            chk_cnt++;
            if ({pbreg, press, release_pulse, rpt} !== 16'h0)
                $display("FAIL glitch edge %0d: got %h required 0000", k, {pbreg, press, release_pulse, rpt});
            else pass_cnt++;
        end
    endtask

    task automatic test_bounce;
        logic [5:0] pattern;
        logic [3:0] exp_pb;
        logic [3:0] exp_ev;
        pattern = 6'b101011;
        // Values applied before edges 1..6: 1,1,0,1,0,1 then steady 1.
        button = {1'b0, pattern[0], 2'b00};
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k < 6) button = {1'b0, pattern[k], 2'b00};
            exp_pb = (k >= 11) ? 4'h4 : 4'h0;
            exp_ev = (k == 11) ? 4'h4 : 4'h0;
            chk_cnt++;
            if (pbreg !== exp_pb)
                $display("FAIL bounce_pbreg edge %0d: got %h required %h", k, pbreg, exp_pb);
            else pass_cnt++;
            chk_cnt++;
            if ({press, release_pulse} !== {exp_ev, 4'h0})
                $display("FAIL bounce_press edge %0d: got %h required %h", k, {press, release_pulse}, {exp_ev, 4'h0});
            else pass_cnt++;
        end
        button = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_ev = (k == 6) ? 4'h4 : 4'h0;
            chk_cnt++;
            if (release_pulse !== exp_ev)
                $display("FAIL bounce_release edge %0d: got %h required %h", k, release_pulse, exp_ev);
            else pass_cnt++;
        end
    endtask

    task automatic test_repeat;
        logic [3:0] exp_rpt;
        logic [3:0] exp_prs;
        logic [3:0] exp_rel;
        // Press edge at 6; release starts after edge 30 and lands on edge 36,
        // which would also be a repeat slot.
        button = 4'h8;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 30) button = 4'h0;
            exp_rpt = (k == 16 || k == 21 || k == 26 || k == 31) ? 4'h8 : 4'h0;
            exp_prs = (k == 6) ? 4'h8 : 4'h0;
            exp_rel = (k == 36) ? 4'h8 : 4'h0;
            chk_cnt++;
            if (rpt !== exp_rpt)
                $display("FAIL repeat_rpt edge %0d: got %h required %h", k, rpt, exp_rpt);
            else pass_cnt++;
            chk_cnt++;
            if ({press, release_pulse} !== {exp_prs, exp_rel})
                $display("FAIL repeat_edges edge %0d: got %h required %h", k, {press, release_pulse}, {exp_prs, exp_rel});
            else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous_reset;
        logic [3:0] exp_prs;
        logic [3:0] exp_rel;
        button = 4'h2;
        for (int k = 1; k <= 8; k++) tick();
        chk_cnt++;
        if (pbreg !== 4'h2)
            $display("FAIL simul_setup: got %h required 2", pbreg);
        else pass_cnt++;
        button = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_prs = (k == 6) ? 4'h1 : 4'h0;
            exp_rel = (k == 6) ? 4'h2 : 4'h0;
            chk_cnt++;
            if ({press, release_pulse} !== {exp_prs, exp_rel})
                $display("FAIL simul_edges edge %0d: got %h required %h", k, {press, release_pulse}, {exp_prs, exp_rel});
            else pass_cnt++;
        end
        // ch0 releasing and ch2 pressing, both mid-count when reset hits.
        button = 4'h4;
        for (int k = 1; k <= 3; k++) tick();
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({pbreg, press, release_pulse, rpt} !== 16'h0)
            $display("FAIL midreset_async: got %h required 0000", {pbreg, press, release_pulse, rpt});
        else pass_cnt++;
        tick();
        button = 4'h0;
        rst_n  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_cnt++;
            if ({pbreg, press, release_pulse, rpt} !== 16'h0)
                $display("FAIL midreset_stale edge %0d: got %h required 0000", k, {pbreg, press, release_pulse, rpt});
            else pass_cnt++;
        end
    endtask

    initial begin
        button = 4'h0;
        rst_n  = 1'b1;
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_repeat();
        test_simultaneous_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
